// File: rtl/simd_div_iter_pkg.sv
// Shared definitions for the SIMD iterative divider: SEW encoding, FSM states
// and helpers that turn a one-hot SEW into element width and iteration count.
package simd_div_iter_pkg;

    localparam int VEC_MIN_WIDTH = 8;
    localparam int VEC_MAX_WIDTH = 64;
    localparam int VEC_SEW_WIDTH = $clog2(VEC_MAX_WIDTH / VEC_MIN_WIDTH) + 1;
    localparam int VEC_CNT_WIDTH = $clog2(VEC_MAX_WIDTH);

    localparam int SEW_64 = 0;
    localparam int SEW_32 = 1;
    localparam int SEW_16 = 2;
    localparam int SEW_8  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Lowest set bit selects the widest element; all-zero falls back to 8-bit.
    function automatic logic [VEC_SEW_WIDTH-1:0] sew_normalize(
        input logic [VEC_SEW_WIDTH-1:0] sew
    );
        logic [VEC_SEW_WIDTH-1:0] res;
        res        = '0;
        res[SEW_8] = 1'b1;
        for (int i = VEC_SEW_WIDTH - 1; i >= 0; i--) begin
            if (sew[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic int elem_width(input logic [VEC_SEW_WIDTH-1:0] sew);
        int w;
        w = VEC_MIN_WIDTH;
        for (int i = VEC_SEW_WIDTH - 1; i >= 0; i--) begin
            if (sew[i]) begin
                w = VEC_MAX_WIDTH >> i;
            end
        end
        return w;
    endfunction

    function automatic logic [VEC_CNT_WIDTH-1:0] iter_count(
        input logic [VEC_SEW_WIDTH-1:0] sew
    );
        return VEC_CNT_WIDTH'(elem_width(sew) - 1);
    endfunction

endpackage

// File: rtl/simd_div_iter_step.sv
// One restoring shift-subtract step applied to every packed element at once;
// the borrow chain is cut at each element boundary chosen by the latched SEW.
module simd_div_step
    import simd_div_iter_pkg::*;
#(
    parameter int MAX_WIDTH = VEC_MAX_WIDTH,
    parameter int MIN_WIDTH = VEC_MIN_WIDTH,
    parameter int SEW_WIDTH = VEC_SEW_WIDTH
) (
    input  logic [SEW_WIDTH-1:0] sew,
    input  logic [MAX_WIDTH-1:0] rem,
    input  logic [MAX_WIDTH-1:0] dvd,
    input  logic [MAX_WIDTH-1:0] dsr,
    output logic [MAX_WIDTH-1:0] rem_nxt,
    output logic [MAX_WIDTH-1:0] dvd_nxt
);

    localparam int NCH = MAX_WIDTH / MIN_WIDTH;
    localparam int IW  = $clog2(MAX_WIDTH);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       brk;
    logic [NCH-1:0]       bout;
    logic [MAX_WIDTH-1:0] rem_sh;
    logic [MAX_WIDTH-1:0] diff;
    logic [MIN_WIDTH:0]   sub;
    logic [IW-1:0]        top;
    logic [CW-1:0]        top_chunk;
    logic                 r_prev;
    logic                 b_prev;
    logic                 d_prev;
    logic                 q_prev;
    logic                 q;
    int                   ec;

    always_comb begin
        brk       = '0;
        bout      = '0;
        rem_sh    = '0;
        diff      = '0;
        sub       = '0;
        top       = '0;
        top_chunk = '0;
        rem_nxt   = '0;
        dvd_nxt   = '0;
        r_prev    = 1'b0;
        b_prev    = 1'b0;
        d_prev    = 1'b0;
        q_prev    = 1'b0;
        q         = 1'b0;
        ec        = elem_width(sew) / MIN_WIDTH;

        for (int c = 0; c < NCH; c++) begin
            brk[c] = (c % ec) == 0;
        end

        // Shift each element left pulling in its dividend MSB, then subtract
        // chunk by chunk with the borrow forced to zero at element starts.
        for (int c = 0; c < NCH; c++) begin
            top = IW'(MIN_WIDTH * (c + ec) - 1);
            rem_sh[c*MIN_WIDTH +: MIN_WIDTH] =
                {rem[c*MIN_WIDTH +: MIN_WIDTH-1], (brk[c] ? dvd[top] : r_prev)};
            sub = {1'b0, rem_sh[c*MIN_WIDTH +: MIN_WIDTH]}
                - {1'b0, dsr[c*MIN_WIDTH +: MIN_WIDTH]}
                - {{MIN_WIDTH{1'b0}}, (brk[c] ? 1'b0 : b_prev)};
            diff[c*MIN_WIDTH +: MIN_WIDTH] = sub[MIN_WIDTH-1:0];
            bout[c] = sub[MIN_WIDTH];
            r_prev  = rem[c*MIN_WIDTH + MIN_WIDTH - 1];
            b_prev  = bout[c];
        end

        // A bit shifted out of the remainder means it already exceeds any
        // divisor, so the subtraction is taken regardless of the borrow.
        for (int c = 0; c < NCH; c++) begin
            top       = IW'(MIN_WIDTH * (c + ec) - 1);
            top_chunk = CW'(c + ec - 1);
            q = brk[c] ? (rem[top] | ~bout[top_chunk]) : q_prev;
            rem_nxt[c*MIN_WIDTH +: MIN_WIDTH] =
                q ? diff[c*MIN_WIDTH +: MIN_WIDTH] : rem_sh[c*MIN_WIDTH +: MIN_WIDTH];
            dvd_nxt[c*MIN_WIDTH +: MIN_WIDTH] =
                {dvd[c*MIN_WIDTH +: MIN_WIDTH-1], (brk[c] ? q : d_prev)};
            q_prev = q;
            d_prev = dvd[c*MIN_WIDTH + MIN_WIDTH - 1];
        end
    end

endmodule

// File: rtl/simd_div_iter.sv
// Iterative SIMD unsigned divider: one restoring step per cycle on all packed
// elements, with sign-fix masks carried alongside for the downstream stage.
//
// state | meaning
// IDLE  | in_ready_o high, waiting for operands
// BUSY  | iterating; final cycle copies results into the output registers
// DONE  | out_valid_o high, result held until out_ready_i
module simd_div_iter
    import simd_div_iter_pkg::*;
#(
    parameter int MIN_WIDTH = VEC_MIN_WIDTH,
    parameter int MAX_WIDTH = VEC_MAX_WIDTH,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [SEW_WIDTH-1:0]           sew_i,
    input  logic [MAX_WIDTH-1:0]           dividend_i,
    input  logic [MAX_WIDTH-1:0]           divisor_i,
    input  logic [MAX_WIDTH/MIN_WIDTH-1:0] neg_q_i,
    input  logic [MAX_WIDTH/MIN_WIDTH-1:0] neg_r_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [MAX_WIDTH-1:0]           quotient_o,
    output logic [MAX_WIDTH-1:0]           remainder_o,
    output logic [MAX_WIDTH/MIN_WIDTH-1:0] neg_q_o,
    output logic [MAX_WIDTH/MIN_WIDTH-1:0] neg_r_o
);

    localparam int NCH = MAX_WIDTH / MIN_WIDTH;
    localparam int CW  = $clog2(MAX_WIDTH);

    div_state_e           state;
    logic [CW-1:0]        count;
    logic                 wb;
    logic [SEW_WIDTH-1:0] sew_q;
    logic [SEW_WIDTH-1:0] sew_in;
    logic [MAX_WIDTH-1:0] rem_q;
    logic [MAX_WIDTH-1:0] dvd_q;
    logic [MAX_WIDTH-1:0] dsr_q;
    logic [MAX_WIDTH-1:0] rem_nxt;
    logic [MAX_WIDTH-1:0] dvd_nxt;
    logic [NCH-1:0]       nq_q;
    logic [NCH-1:0]       nr_q;
    logic                 accept;

    assign in_ready_o = (state == IDLE);
    assign accept     = in_valid_i && in_ready_o;
    assign sew_in     = sew_normalize(sew_i);

    simd_div_step #(
        .MAX_WIDTH (MAX_WIDTH),
        .MIN_WIDTH (MIN_WIDTH),
        .SEW_WIDTH (SEW_WIDTH)
    ) u_step (
        .sew     (sew_q),
        .rem     (rem_q),
        .dvd     (dvd_q),
        .dsr     (dsr_q),
        .rem_nxt (rem_nxt),
        .dvd_nxt (dvd_nxt)
    );

    // The dividend register doubles as the quotient accumulator: quotient
    // bits enter at each element LSB as dividend bits leave at the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            wb          <= 1'b0;
            sew_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            nq_q        <= '0;
            nr_q        <= '0;
            out_valid_o <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            neg_q_o     <= '0;
            neg_r_o     <= '0;
        end else if (flush_i) begin
            state       <= IDLE;
            wb          <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                        sew_q <= sew_in;
                        dvd_q <= dividend_i;
                        dsr_q <= divisor_i;
                        rem_q <= '0;
                        nq_q  <= neg_q_i;
                        nr_q  <= neg_r_i;
                        count <= iter_count(sew_in);
                        wb    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!wb) begin
                        rem_q <= rem_nxt;
                        dvd_q <= dvd_nxt;
                        if (count == '0) begin
                            wb <= 1'b1;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end else begin
                        quotient_o  <= dvd_q;
                        remainder_o <= rem_q;
                        neg_q_o     <= nq_q;
                        neg_r_o     <= nr_q;
                        out_valid_o <= 1'b1;
                        wb          <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_div_iter.sv
// Directed bench for simd_div_iter: table of hand-computed vectors plus
// sequences for backpressure, flush and mid-operation reset.
module tb_simd_div_iter;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  sew_i;
    logic [63:0] dividend_i;
    logic [63:0] divisor_i;
    logic [7:0]  neg_q_i;
    logic [7:0]  neg_r_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] quotient_o;
    logic [63:0] remainder_o;
    logic [7:0]  neg_q_o;
    logic [7:0]  neg_r_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  sew;
        logic [63:0] dvd;
        logic [63:0] dsr;
        logic [7:0]  nq;
        logic [7:0]  nr;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    simd_div_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sew_i       (sew_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .neg_q_i     (neg_q_i),
        .neg_r_i     (neg_r_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .neg_q_o     (neg_q_o),
        .neg_r_o     (neg_r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input vec_t v);
        @(negedge clk);
        chk("ready_before_op", 64'(in_ready_o), 64'd1);
        sew_i      = v.sew;
        dividend_i = v.dvd;
        divisor_i  = v.dsr;
        neg_q_i    = v.nq;
        neg_r_i    = v.nr;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        neg_q_i    = '0;
        neg_r_i    = '0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid_o && cyc < 200);
        if (!out_valid_o) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", cyc);
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic check_result(input vec_t v, input int cyc);
        chk("latency", 64'(cyc), 64'(v.lat));
        chk("quotient", quotient_o, v.q);
        chk("remainder", remainder_o, v.r);
        chk("neg_q_o", 64'(neg_q_o), 64'(v.nq));
        chk("neg_r_o", 64'(neg_r_o), 64'(v.nr));
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0] = '{4'b1000, 64'h6464_6464_6464_6464, 64'h0707_0707_0707_0707, 8'hA5, 8'h0F,
                    64'h0E0E_0E0E_0E0E_0E0E, 64'h0202_0202_0202_0202, 9};
        vecs[1] = '{4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003, 8'h3C, 8'hC3,
                    64'h5555_5555_5555_5555, 64'h0, 65};
        vecs[2] = '{4'b0100, 64'h8000_FFFF_1234_0064, 64'h0003_0100_0000_0007, 8'h01, 8'h80,
                    64'h2AAA_00FF_FFFF_000E, 64'h0002_00FF_1234_0002, 17};
        vecs[3] = '{4'b0010, 64'h000F_4240_FFFF_FFFF, 64'h0000_03E8_FFFF_FFFF, 8'hFF, 8'h00,
                    64'h0000_03E8_0000_0001, 64'h0, 33};
        vecs[4] = '{4'b1000, 64'h55FE_07C8_8000_FFFF, 64'h007F_020A_8100_FF01, 8'h5A, 8'h96,
                    64'hFF02_0314_00FF_01FF, 64'h5500_0100_8000_0000, 9};
        vecs[5] = '{4'b0110, 64'h0000_0064_0000_0064, 64'h0000_0007_0000_0007, 8'h12, 8'h34,
                    64'h0000_000E_0000_000E, 64'h0000_0002_0000_0002, 33};
        vecs[6] = '{4'b0000, 64'h0000_0000_0000_0064, 64'h0000_0000_0000_0007, 8'h00, 8'hFF,
                    64'hFFFF_FFFF_FFFF_FF0E, 64'h0000_0000_0000_0002, 9};
        vecs[7] = '{4'b0001, 64'h1234_5678_9ABC_DEF0, 64'h0, 8'h81, 8'h7E,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 65};

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        sew_i       = '0;
        dividend_i  = '0;
        divisor_i   = '0;
        neg_q_i     = '0;
        neg_r_i     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid_o), 64'd0);
        chk("reset_quotient", quotient_o, 64'd0);
        chk("reset_remainder", remainder_o, 64'd0);
        chk("reset_in_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i]);
            wait_valid(cyc);
            check_result(vecs[i], cyc);
            ack();
            chk("post_ack_valid", 64'(out_valid_o), 64'd0);
            chk("post_ack_ready", 64'(in_ready_o), 64'd1);
        end

        // Backpressure: result and masks must hold while the consumer stalls.
        start_op(vecs[0]);
        wait_valid(cyc);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_ready", 64'(in_ready_o), 64'd0);
            chk("bp_quotient", quotient_o, vecs[0].q);
            chk("bp_remainder", remainder_o, vecs[0].r);
            chk("bp_neg_q", 64'(neg_q_o), 64'(vecs[0].nq));
            chk("bp_neg_r", 64'(neg_r_o), 64'(vecs[0].nr));
        end
        ack();
        chk("bp_release_ready", 64'(in_ready_o), 64'd1);
        start_op(vecs[2]);
        wait_valid(cyc);
        check_result(vecs[2], cyc);
        ack();

        // Flush during iteration aborts without ever raising out_valid_o.
        start_op(vecs[1]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_busy_valid", 64'(out_valid_o), 64'd0);
        chk("flush_busy_ready", 64'(in_ready_o), 64'd1);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid_o) seen++;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        sew_i      = vecs[0].sew;
        dividend_i = vecs[0].dvd;
        divisor_i  = vecs[0].dsr;
        in_valid_i = 1'b1;
        flush_i    = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        chk("flush_vs_accept_ready", 64'(in_ready_o), 64'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid_o) seen++;
        end
        chk("flush_vs_accept_no_result", 64'(seen), 64'd0);

        // Flush together with out_ready_i in DONE discards the result.
        start_op(vecs[4]);
        wait_valid(cyc);
        check_result(vecs[4], cyc);
        @(negedge clk);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        chk("flush_done_valid", 64'(out_valid_o), 64'd0);
        chk("flush_done_ready", 64'(in_ready_o), 64'd1);

        // Reset in the middle of an operation clears every output.
        start_op(vecs[3]);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_quotient", quotient_o, 64'd0);
        chk("midrst_remainder", remainder_o, 64'd0);
        chk("midrst_neg_q", 64'(neg_q_o), 64'd0);
        chk("midrst_neg_r", 64'(neg_r_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(in_ready_o), 64'd1);
        start_op(vecs[5]);
        wait_valid(cyc);
        check_result(vecs[5], cyc);
        ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
